pic_inta_eoi_controller: RTL and testbench
==========================================

# pic_inta_eoi_controller

Drives the in-service register of the 8259-compatible PIC from the CPU side. Sequences the INTA pulses, selects the level being acknowledged, pulses the in-service latch and drives the vector bytes onto the data bus. Decodes OCW2 into end-of-interrupt clear masks and priority-rotation updates. Sits between the bus interface/ICW registers and the in-service register and priority resolver.

## Interface
- No parameters.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `inta_n` in 1 — CPU interrupt acknowledge strobe, active low, asynchronous to `clk`.
- `mode_8086` in 1 — ICW4 uPM: 1 = two-pulse 8086 sequence, 0 = three-pulse 8080 sequence.
- `auto_eoi` in 1 — ICW4 AEOI.
- `adi` in 1 — ICW1 call address interval: 1 = 4, 0 = 8 (8080 mode only).
- `icw1_addr` in 3 — ICW1 A7..A5.
- `icw2` in 8 — ICW2 (vector T7..T3, or 8080 high address byte).
- `interrupt_request_resolved` in 8 — one-hot highest pending unmasked request, or 0.
- `highest_level_in_service` in 8 — one-hot from the in-service register.
- `ocw2_write` in 1 — one-cycle OCW2 write strobe.
- `ocw2_data` in 8 — {R, SL, EOI, 2'b00, L2..L0}.
- `latch_in_service` out 1 — one-cycle set pulse to the in-service register.
- `interrupt_to_service` out 8 — one-hot acknowledged level.
- `end_of_interrupt` out 8 — one-cycle clear mask.
- `priority_rotate` out 3 — level currently holding lowest priority.
- `data_out` out 8 — vector byte.
- `data_out_en` out 1 — data bus drive enable.

## Operation
- `inta_n` passes through a 2-flop synchronizer and an edge detector. Falling and rising edges act on the synchronized signal only.
- FSM states are IDLE, ACK1, ACK2, ACK3. All transitions happen on synchronized edges.
  - IDLE, fall: capture `interrupt_request_resolved` into `interrupt_to_service` and pulse `latch_in_service`, then go to ACK1.
  - If the captured value is 0, the acknowledge is spurious: no latch pulse, `interrupt_to_service`=0, and the vector uses level 7.
  - ACK1, rise: hold in ACK1. The next fall goes to ACK2.
  - ACK2, rise: in 8086 mode, end the sequence and go to IDLE. In 8080 mode, the next fall goes to ACK3.
  - ACK3, rise: end the sequence and go to IDLE.
- Data bus output while `inta_n` (synchronized) is low:
  - 8086 mode, pulse 1: `data_out_en`=0.
  - 8086 mode, pulse 2: `data_out`={icw2[7:3], L}, where L is the binary index of the acknowledged level.
  - 8080 mode, pulse 1: `data_out`=0xCD.
  - 8080 mode, pulse 2: `data_out`={icw1_addr, L, 2'b00} when adi=1, or {icw1_addr[2:1], L, 3'b000} when adi=0.
  - 8080 mode, pulse 3: `data_out`=icw2.
- End of sequence with `auto_eoi`=1 and a non-spurious acknowledge: `end_of_interrupt`=`interrupt_to_service` for one cycle. If the AEOI-rotate flag is set, `priority_rotate` is set to L.
- OCW2 decode of {R,SL,EOI}:
  - 001 non-specific EOI: `end_of_interrupt`=`highest_level_in_service`.
  - 011 specific EOI: `end_of_interrupt`=one-hot(L).
  - 101 rotate on non-specific EOI: non-specific EOI, and `priority_rotate` is set to the index of `highest_level_in_service`. No change if it is 0.
  - 111 rotate on specific EOI: specific EOI, and `priority_rotate` is set to L.
  - 110 set priority: `priority_rotate` is set to L.
  - 100 sets the AEOI-rotate flag; 000 clears it.
  - 010 is a no-op.
- Non-specific EOI with `highest_level_in_service`=0 gives `end_of_interrupt`=0.

## Timing
- Reset values:
  - FSM in IDLE, synchronizer flops = 1.
  - `latch_in_service`=0, `interrupt_to_service`=0, `end_of_interrupt`=0.
  - `priority_rotate`=3'd7, AEOI-rotate flag = 0.
  - `data_out`=0, `data_out_en`=0.
- `latch_in_service` and the capture fire in the 3rd rising `clk` edge after `inta_n` falls.
- `data_out_en` follows the synchronized strobe with the same 3-cycle latency on both edges.
- The OCW2 result is registered and appears in the cycle after `ocw2_write`.
- AEOI `end_of_interrupt` is asserted in the cycle after the final synchronized rise.
- If an OCW2 EOI and an AEOI pulse land in the same cycle, `end_of_interrupt` is their OR. If both update `priority_rotate`, OCW2 wins.
- `interrupt_request_resolved` changing mid-sequence has no effect. The level is frozen from ACK1 until IDLE.
- Reset mid-sequence aborts to IDLE with all outputs at their reset values. A later `inta_n` rise is ignored.

## Configuration
- Macro `PIC_AUTO_EOI_EN`.
- Defined: auto-EOI and the rotate-in-AEOI commands (100/000) work as described.
- Undefined: `auto_eoi` is ignored, OCW2 100/000 are no-ops, the AEOI-rotate flag is absent, and the end of a sequence never produces `end_of_interrupt`.

## Test plan
- 8086 mode, icw2=0x40, resolved=0x08, two INTA pulses: one `latch_in_service` pulse, `interrupt_to_service`=0x08, pulse 1 `data_out_en`=0, pulse 2 `data_out`=0x43.
- 8080 mode, adi=1, icw1_addr=3'b101, icw2=0x12, resolved=0x04: bytes 0xCD, 0xA8, 0x12. With adi=0 the second byte is 0x90.
- OCW2 0x20 with ISR highest=0x10: `end_of_interrupt`=0x10 for one cycle. OCW2 0xE5: `end_of_interrupt`=0x20 and `priority_rotate`=5.
- auto_eoi=1, OCW2 0x80, then acknowledge IR2: after the last rise, `end_of_interrupt`=0x04 and `priority_rotate`=2. Repeat with the macro undefined: no EOI, rotate stays at 7.
- INTA with resolved=0: no latch pulse, 8086 vector = {icw2[7:3], 3'd7}.
- Assert `rst_n` low between the two 8086 pulses: outputs at reset values. The next INTA starts a fresh sequence from ACK1.

Source files
------------

// File: rtl/pic_inta_eoi_if.sv
// CPU-side acknowledge and OCW2 bundle for the 8259 INTA/EOI controller.
// The master drives the strobes and configuration; the slave is the controller.
interface pic_inta_eoi_if;
    logic       inta_n;
    logic       mode_8086;
    logic       auto_eoi;
    logic       adi;
    logic [2:0] icw1_addr;
    logic [7:0] icw2;
    logic [7:0] interrupt_request_resolved;
    logic [7:0] highest_level_in_service;
    logic       ocw2_write;
    logic [7:0] ocw2_data;
    logic       latch_in_service;
    logic [7:0] interrupt_to_service;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output inta_n, mode_8086, auto_eoi, adi, icw1_addr, icw2,
        output interrupt_request_resolved, highest_level_in_service,
        output ocw2_write, ocw2_data,
        input  latch_in_service, interrupt_to_service, end_of_interrupt,
        input  priority_rotate, data_out, data_out_en
    );

    modport slave (
        input  inta_n, mode_8086, auto_eoi, adi, icw1_addr, icw2,
        input  interrupt_request_resolved, highest_level_in_service,
        input  ocw2_write, ocw2_data,
        output latch_in_service, interrupt_to_service, end_of_interrupt,
        output priority_rotate, data_out, data_out_en
    );
endinterface

// File: rtl/pic_inta_eoi_controller.sv
// 8259 INTA sequencer, vector driver and OCW2 EOI/rotation decoder.
// Define PIC_AUTO_EOI_EN to enable auto-EOI and the rotate-in-AEOI commands.
module pic_inta_eoi_controller (
    input  logic          clk,
    input  logic          rst_n,
    pic_inta_eoi_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_e;

    state_e     state_q, state_d;
    logic       sync1_q, sync2_q, sync3_q;
    logic       fall, rise, end_seq;
    logic [7:0] its_q, its_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       latch_q, latch_d;
    logic [7:0] eoi_q, eoi_d;
    logic [2:0] rot_q, rot_d;
    logic [7:0] dout_q, dout_d;
    logic       den_q, den_d;
    logic [2:0] ocw_l;
    logic [7:0] ocw_oh;
`ifdef PIC_AUTO_EOI_EN
    logic       arot_q, arot_d;
`endif

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign fall   = sync3_q & ~sync2_q;
    assign rise   = ~sync3_q & sync2_q;
    assign ocw_l  = bus.ocw2_data[2:0];
    assign ocw_oh = 8'b1 << ocw_l;

    always_comb begin
        state_d = state_q;
        its_d   = its_q;
        lvl_d   = lvl_q;
        spur_d  = spur_q;
        latch_d = 1'b0;
        end_seq = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall) begin
                    its_d   = bus.interrupt_request_resolved;
                    spur_d  = (bus.interrupt_request_resolved == 8'h00);
                    lvl_d   = spur_d ? 3'd7
                                     : enc8(bus.interrupt_request_resolved);
                    latch_d = ~spur_d;
                    state_d = ACK1;
                end
            end
            ACK1: begin
                if (fall) state_d = ACK2;
            end
            ACK2: begin
                if (rise && bus.mode_8086) begin
                    state_d = IDLE;
                    end_seq = 1'b1;
                end else if (fall && !bus.mode_8086) begin
                    state_d = ACK3;
                end
            end
            ACK3: begin
                if (rise) begin
                    state_d = IDLE;
                    end_seq = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus byte is chosen by the pulse the FSM is entering or holding.
    always_comb begin
        den_d  = 1'b0;
        dout_d = 8'h00;
        if (!sync2_q) begin
            unique case (state_d)
                ACK1: begin
                    if (!bus.mode_8086) begin
                        den_d  = 1'b1;
                        dout_d = 8'hCD;
                    end
                end
                ACK2: begin
                    den_d = 1'b1;
                    if (bus.mode_8086)
                        dout_d = {bus.icw2[7:3], lvl_d};
                    else if (bus.adi)
                        dout_d = {bus.icw1_addr, lvl_d, 2'b00};
                    else
                        dout_d = {bus.icw1_addr[2:1], lvl_d, 3'b000};
                end
                ACK3: begin
                    den_d  = 1'b1;
                    dout_d = bus.icw2;
                end
                default: ;
            endcase
        end
    end

    // OCW2 is applied after AEOI so its rotation takes precedence.
    always_comb begin
        eoi_d = 8'h00;
        rot_d = rot_q;
`ifdef PIC_AUTO_EOI_EN
        arot_d = arot_q;
        if (end_seq && bus.auto_eoi && !spur_q) begin
            eoi_d = its_q;
            if (arot_q) rot_d = lvl_q;
        end
`endif
        if (bus.ocw2_write) begin
            unique case (bus.ocw2_data[7:5])
                3'b001: eoi_d = eoi_d | bus.highest_level_in_service;
                3'b011: eoi_d = eoi_d | ocw_oh;
                3'b101: begin
                    eoi_d = eoi_d | bus.highest_level_in_service;
                    if (bus.highest_level_in_service != 8'h00)
                        rot_d = enc8(bus.highest_level_in_service);
                end
                3'b111: begin
                    eoi_d = eoi_d | ocw_oh;
                    rot_d = ocw_l;
                end
                3'b110: rot_d = ocw_l;
`ifdef PIC_AUTO_EOI_EN
                3'b100: arot_d = 1'b1;
                3'b000: arot_d = 1'b0;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
            state_q <= IDLE;
            its_q   <= 8'h00;
            lvl_q   <= 3'd0;
            spur_q  <= 1'b0;
            latch_q <= 1'b0;
            eoi_q   <= 8'h00;
            rot_q   <= 3'd7;
            dout_q  <= 8'h00;
            den_q   <= 1'b0;
`ifdef PIC_AUTO_EOI_EN
            arot_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= bus.inta_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            its_q   <= its_d;
            lvl_q   <= lvl_d;
            spur_q  <= spur_d;
            latch_q <= latch_d;
            eoi_q   <= eoi_d;
            rot_q   <= rot_d;
            dout_q  <= dout_d;
            den_q   <= den_d;
`ifdef PIC_AUTO_EOI_EN
            arot_q  <= arot_d;
`endif
        end
    end

`ifdef PIC_AUTO_EOI_EN
    logic unused_ok;
    assign unused_ok = ^bus.ocw2_data[4:3];
`else
    logic unused_ok;
    assign unused_ok = ^{bus.ocw2_data[4:3], bus.auto_eoi, spur_q, end_seq};
`endif

    assign bus.latch_in_service     = latch_q;
    assign bus.interrupt_to_service = its_q;
    assign bus.end_of_interrupt     = eoi_q;
    assign bus.priority_rotate      = rot_q;
    assign bus.data_out             = dout_q;
    assign bus.data_out_en          = den_q;

endmodule

// File: tb/tb_pic_inta_eoi_controller.sv
// Directed bench for pic_inta_eoi_controller: INTA sequences, vectors,
// OCW2 decode, spurious acknowledge, reset abort and auto-EOI.
module tb_pic_inta_eoi_controller;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pic_inta_eoi_if bus ();

    pic_inta_eoi_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic inta_fall();
        @(negedge clk);
        bus.inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic inta_rise();
        @(negedge clk);
        bus.inta_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ocw_wr(input logic [7:0] d);
        @(negedge clk);
        bus.ocw2_write = 1'b1;
        bus.ocw2_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic ocw_end();
        @(negedge clk);
        bus.ocw2_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.inta_n = 1'b1;
        bus.mode_8086 = 1'b1;
        bus.auto_eoi = 1'b0;
        bus.adi = 1'b0;
        bus.icw1_addr = 3'd0;
        bus.icw2 = 8'h40;
        bus.interrupt_request_resolved = 8'h08;
        bus.highest_level_in_service = 8'h00;
        bus.ocw2_write = 1'b0;
        bus.ocw2_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_latch", {7'd0, bus.latch_in_service}, 8'h00);
        chk("rst_its", bus.interrupt_to_service, 8'h00);
        chk("rst_eoi", bus.end_of_interrupt, 8'h00);
        chk("rst_rot", {5'd0, bus.priority_rotate}, 8'h07);
        chk("rst_dout", bus.data_out, 8'h00);
        chk("rst_den", {7'd0, bus.data_out_en}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) next_cycle();

        // 8086 two-pulse sequence, with latency probe on pulse 1
        @(negedge clk);
        bus.inta_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("86_latch_early", {7'd0, bus.latch_in_service}, 8'h00);
        next_cycle();
        chk("86_latch", {7'd0, bus.latch_in_service}, 8'h01);
        chk("86_its", bus.interrupt_to_service, 8'h08);
        chk("86_p1_den", {7'd0, bus.data_out_en}, 8'h00);
        bus.interrupt_request_resolved = 8'h80;
        next_cycle();
        chk("86_latch_1cyc", {7'd0, bus.latch_in_service}, 8'h00);
        inta_rise();
        inta_fall();
        chk("86_p2_den", {7'd0, bus.data_out_en}, 8'h01);
        chk("86_p2_dout", bus.data_out, 8'h43);
        chk("86_p2_latch", {7'd0, bus.latch_in_service}, 8'h00);
        chk("86_its_frozen", bus.interrupt_to_service, 8'h08);
        inta_rise();
        chk("86_end_den", {7'd0, bus.data_out_en}, 8'h00);
        chk("86_end_eoi", bus.end_of_interrupt, 8'h00);

        // 8080 three-pulse sequence, adi=1
        bus.mode_8086 = 1'b0;
        bus.adi = 1'b1;
        bus.icw1_addr = 3'b101;
        bus.icw2 = 8'h12;
        bus.interrupt_request_resolved = 8'h04;
        inta_fall();
        chk("80_p1_den", {7'd0, bus.data_out_en}, 8'h01);
        chk("80_p1_dout", bus.data_out, 8'hCD);
        chk("80_its", bus.interrupt_to_service, 8'h04);
        inta_rise();
        chk("80_gap_den", {7'd0, bus.data_out_en}, 8'h00);
        inta_fall();
        chk("80_p2_adi1", bus.data_out, 8'hA8);
        inta_rise();
        inta_fall();
        chk("80_p3_dout", bus.data_out, 8'h12);
        chk("80_p3_den", {7'd0, bus.data_out_en}, 8'h01);
        inta_rise();
        chk("80_end_den", {7'd0, bus.data_out_en}, 8'h00);

        // 8080 with adi=0
        bus.adi = 1'b0;
        inta_fall();
        chk("80b_p1_dout", bus.data_out, 8'hCD);
        inta_rise();
        inta_fall();
        chk("80_p2_adi0", bus.data_out, 8'h90);
        inta_rise();
        inta_fall();
        chk("80b_p3_dout", bus.data_out, 8'h12);
        inta_rise();

        // OCW2 decode
        bus.highest_level_in_service = 8'h10;
        ocw_wr(8'h20);
        chk("ns_eoi", bus.end_of_interrupt, 8'h10);
        chk("ns_rot", {5'd0, bus.priority_rotate}, 8'h07);
        ocw_end();
        chk("ns_eoi_1cyc", bus.end_of_interrupt, 8'h00);
        ocw_wr(8'hA0);
        chk("rns_eoi", bus.end_of_interrupt, 8'h10);
        chk("rns_rot", {5'd0, bus.priority_rotate}, 8'h04);
        ocw_end();
        ocw_wr(8'hC3);
        chk("setpri_eoi", bus.end_of_interrupt, 8'h00);
        chk("setpri_rot", {5'd0, bus.priority_rotate}, 8'h03);
        ocw_end();
        ocw_wr(8'h61);
        chk("spec_eoi", bus.end_of_interrupt, 8'h02);
        chk("spec_rot", {5'd0, bus.priority_rotate}, 8'h03);
        ocw_end();
        ocw_wr(8'hE5);
        chk("rspec_eoi", bus.end_of_interrupt, 8'h20);
        chk("rspec_rot", {5'd0, bus.priority_rotate}, 8'h05);
        ocw_end();
        bus.highest_level_in_service = 8'h00;
        ocw_wr(8'h20);
        chk("ns_empty_eoi", bus.end_of_interrupt, 8'h00);
        ocw_end();

        // Spurious acknowledge in 8086 mode
        bus.mode_8086 = 1'b1;
        bus.icw2 = 8'h40;
        bus.interrupt_request_resolved = 8'h00;
        inta_fall();
        chk("spur_latch", {7'd0, bus.latch_in_service}, 8'h00);
        chk("spur_its", bus.interrupt_to_service, 8'h00);
        inta_rise();
        inta_fall();
        chk("spur_dout", bus.data_out, 8'h47);
        inta_rise();

        // Reset between the two 8086 pulses
        bus.interrupt_request_resolved = 8'h08;
        inta_fall();
        inta_rise();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_its", bus.interrupt_to_service, 8'h00);
        chk("mid_rst_rot", {5'd0, bus.priority_rotate}, 8'h07);
        chk("mid_rst_den", {7'd0, bus.data_out_en}, 8'h00);
        chk("mid_rst_dout", bus.data_out, 8'h00);
        chk("mid_rst_eoi", bus.end_of_interrupt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) next_cycle();
        bus.interrupt_request_resolved = 8'h20;
        inta_fall();
        chk("fresh_latch", {7'd0, bus.latch_in_service}, 8'h01);
        chk("fresh_its", bus.interrupt_to_service, 8'h20);
        chk("fresh_p1_den", {7'd0, bus.data_out_en}, 8'h00);
        inta_rise();
        inta_fall();
        chk("fresh_p2_dout", bus.data_out, 8'h45);
        inta_rise();

        // Auto-EOI with AEOI rotation requested
        bus.auto_eoi = 1'b1;
        ocw_wr(8'h80);
        ocw_end();
        bus.interrupt_request_resolved = 8'h04;
        inta_fall();
        inta_rise();
        inta_fall();
        chk("aeoi_p2_dout", bus.data_out, 8'h42);
        inta_rise();
`ifdef PIC_AUTO_EOI_EN
        chk("aeoi_eoi", bus.end_of_interrupt, 8'h04);
        chk("aeoi_rot", {5'd0, bus.priority_rotate}, 8'h02);
`else
        chk("aeoi_eoi", bus.end_of_interrupt, 8'h00);
        chk("aeoi_rot", {5'd0, bus.priority_rotate}, 8'h07);
`endif
        next_cycle();
        chk("aeoi_eoi_1cyc", bus.end_of_interrupt, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
